// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding and
// baud-divider arithmetic.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // sclk cycles per line bit; integer division truncates any remainder.
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with show-ahead read data and a separate occupancy
// counter; a write while full is dropped even if a read happens alongside.
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_acc, rd_acc;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: every signal gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the cleared count makes stale
  // contents unreachable and keeps the array mappable to plain RAM.
  always_ff @(posedge sclk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes queue in uart_fifo and are shifted
// out LSB first, with back-to-back frames leaving no idle gap.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sclk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        ovf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        busy,
  output logic                        tx
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int BCW      = cnt_width(BAUD_DIV);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] BAUD_ONE  = BCW'(1);

  tx_state_e      state_q, state_d;
  logic [BCW-1:0] baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;
  logic           avail_q, avail_d;
  logic           pop, baud_end, fifo_empty;
  logic [7:0]     fifo_rd_data;

  uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (pop),
    .rd_data(fifo_rd_data),
    .full   (full),
    .empty  (fifo_empty),
    .cnt    (fifo_cnt)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      // Launch from idle uses the registered non-empty flag, so the start
      // bit leaves two edges after the write that filled an empty buffer.
      ST_IDLE: begin
        if (avail_q && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so tx and busy line up
    // with the state they describe.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d  = (state_d != ST_IDLE);
    avail_d = !fifo_empty;
    ovf_d   = wr_en && full;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      avail_q <= avail_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: a timeline model of accepted frames
// predicts line, status and overflow each cycle; a frame decoder checks bytes.
module tb_uart_tx_buf;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int BIT_T    = CLK_FREQ / BAUD;
  localparam int FRAME_T  = 10 * BIT_T;

  typedef struct {
    int         w;
    int         start;
    logic [7:0] data;
  } frame_t;

  logic       sclk = 1'b0;
  logic       rst_n, wr_en;
  logic [7:0] wr_data;
  logic       full, ovf, busy, tx;
  logic [2:0] fifo_cnt;

  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  frame_t frames[$];
  frame_t sb[$];
  int     drops[$];

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc++;

  uart_tx_buf #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .ovf     (ovf),
    .fifo_cnt(fifo_cnt),
    .busy    (busy),
    .tx      (tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: each accepted byte owns a 100-cycle window on the line.
  function automatic int last_end();
    return (frames.size() > 0) ? frames[frames.size()-1].start + FRAME_T : 0;
  endfunction

  function automatic int model_cnt(input int c);
    int n = 0;
    foreach (frames[i]) begin
      if (frames[i].w <= c)     n++;
      if (frames[i].start <= c) n--;
    end
    return n;
  endfunction

  function automatic logic model_tx(input int c);
    foreach (frames[i]) begin
      if (frames[i].start <= c && c < frames[i].start + FRAME_T) begin
        int idx = (c - frames[i].start) / BIT_T;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return frames[i].data[idx-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic model_busy(input int c);
    foreach (frames[i])
      if (frames[i].start <= c && c < frames[i].start + FRAME_T) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_ovf(input int c);
    foreach (drops[i]) if (drops[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one write at the next edge; s returns the predicted start cycle or -1.
  task automatic wr(input logic [7:0] d, output int s);
    int     w;
    frame_t f;
    w = cyc + 1;
    if (model_cnt(w - 1) >= DEPTH) begin
      drops.push_back(w);
      s = -1;
    end else begin
      s = (frames.size() > 0 && w < last_end()) ? last_end() : w + 2;
      f.w = w;
      f.start = s;
      f.data = d;
      frames.push_back(f);
      sb.push_back(f);
    end
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge sclk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sclk);
  endtask

  task automatic model_reset();
    frames.delete();
    sb.delete();
    drops.delete();
  endtask

  always @(negedge sclk) begin
    if (!rst_n) begin
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_full", full, 0);
      check("rst_ovf", ovf, 0);
      check("rst_fifo_cnt", fifo_cnt, 0);
    end else begin
      check("tx", tx, model_tx(cyc));
      check("busy", busy, model_busy(cyc));
      check("fifo_cnt", fifo_cnt, model_cnt(cyc));
      check("full", full, model_cnt(cyc) == DEPTH);
      check("ovf", ovf, model_ovf(cyc));
    end
  end

  // Frame decoder: pops the scoreboard on each start bit, samples mid-bit.
  logic       in_frame = 1'b0;
  int         f_start, off;
  logic [7:0] rx;
  frame_t     f_exp;

  always @(negedge sclk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        f_start  = cyc;
        check("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          f_exp = sb.pop_front();
          check("frame_start_cycle", cyc, f_exp.start);
        end else begin
          f_exp.start = -1;
          f_exp.data  = 8'h00;
        end
      end
    end else begin
      off = cyc - f_start;
      if (off >= BIT_T && off < 9 * BIT_T && off % BIT_T == BIT_T / 2)
        rx[off / BIT_T - 1] = tx;
      if (off == 9 * BIT_T + BIT_T / 2) begin
        check("frame_data", rx, f_exp.data);
        check("frame_stop_bit", tx, 1);
      end
      if (off == FRAME_T - 1) in_frame = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s0, s1, s55, s11, e, dummy;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge sclk);
    rst_n = 1'b1;

    // Single byte from idle.
    wr(8'hA5, s);
    wait_until(s - 1);
    check("a5_tx_idle_n1", tx, 1);
    check("a5_busy_n1", busy, 0);
    wait_until(s);
    check("a5_tx_start_n2", tx, 0);
    check("a5_busy_start", busy, 1);
    wait_until(s + FRAME_T - 1);
    check("a5_busy_last_stop", busy, 1);
    wait_until(s + FRAME_T);
    check("a5_busy_done", busy, 0);

    // Back-to-back frames.
    wr(8'h00, s0);
    check("b2b_cnt_1", fifo_cnt, 1);
    wr(8'hFF, s1);
    check("b2b_cnt_2", fifo_cnt, 2);
    wait_until(s0);
    check("b2b_cnt_pop1", fifo_cnt, 1);
    wait_until(s1);
    check("b2b_cnt_pop2", fifo_cnt, 0);
    wait_until(last_end() + 3);

    // Overflow while busy, then write-while-full on a pop cycle.
    wr(8'h55, s55);
    repeat (20) @(negedge sclk);
    wr(8'h11, s11);
    wr(8'h12, dummy);
    wr(8'h13, dummy);
    wr(8'h14, dummy);
    check("ovf_full_after_4", full, 1);
    check("ovf_cnt_4", fifo_cnt, 4);
    wr(8'h15, dummy);
    check("ovf_pulse_0x15", ovf, 1);
    e = s55 + FRAME_T;
    wait_until(e - 1);
    wr(8'h77, dummy);
    check("sim_full_pop_ovf", ovf, 1);
    check("sim_full_pop_cnt", fifo_cnt, 3);
    wait_until(s11 + FRAME_T - 1);
    wr(8'h78, dummy);
    check("sim_cnt3_pop_cnt", fifo_cnt, 3);
    wait_until(last_end() + 3);

    // Reset during bit 3 of 0x3C with another byte buffered.
    wr(8'h3C, s);
    wr(8'h99, dummy);
    wait_until(s + 4 * BIT_T + 2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_cnt", fifo_cnt, 0);
    check("rst_mid_busy", busy, 0);
    repeat (3) @(negedge sclk);
    rst_n = 1'b1;
    wr(8'h81, s);
    wait_until(s + FRAME_T + 2);

    // Pointer wrap: 12 bytes through the depth-4 buffer, never overfilled.
    for (int i = 1; i <= 12; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge sclk);
      while (model_cnt(cyc) >= DEPTH) @(negedge sclk);
      wr(8'(i), dummy);
    end

    // Random traffic, overflow allowed.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 50)) @(negedge sclk);
      wr(8'($urandom), dummy);
    end

    wait_until(last_end() + 5);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
